// File: rtl/ibex_data_bus_pkg.sv
// Shared constants for the data-bus arbiter slice: host indices and the
// width helper for the outstanding-transaction counter.
package ibex_data_bus_pkg;

    localparam int HOST_LSU  = 0;
    localparam int HOST_ACC  = 1;
    localparam int NUM_HOSTS = 2;

    // Counter wide enough to hold 0..max_out inclusive.
    function automatic int calc_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/ibex_data_bus_id_fifo.sv
// One-bit-wide ID FIFO recording which host owns each granted transaction.
// Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
module ibex_data_bus_id_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_data,
    input  logic             pop,
    output logic             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_data_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the LSU (host 0)
// and the accelerator/DMA port (host 1). Responses are routed back in grant
// order through the ID FIFO. No added latency on any path.
//
//   lock_q | meaning
//   -------+-----------------------------------------------------------
//   0      | free: selection follows the round-robin rules
//   1      | a request to sel_q is stalled by the device; selection held
module ibex_data_bus_arbiter
    import ibex_data_bus_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 2,
    localparam int CNT_W           = calc_cnt_w(MAX_OUTSTANDING)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HOSTS-1:0] host_req_i,
    input  logic [NUM_HOSTS-1:0] host_we_i,
    input  logic [7:0]           host_be_i,
    input  logic [63:0]          host_addr_i,
    input  logic [63:0]          host_wdata_i,
    output logic [NUM_HOSTS-1:0] host_gnt_o,
    output logic [NUM_HOSTS-1:0] host_rvalid_o,
    output logic [NUM_HOSTS-1:0] host_err_o,
    output logic [31:0]          host_rdata_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [31:0]          data_addr_o,
    output logic [31:0]          data_wdata_o,
    input  logic                 data_rvalid_i,
    input  logic                 data_err_i,
    input  logic [31:0]          data_rdata_i,
    output logic [CNT_W-1:0]     outstanding_o,
    output logic                 protocol_err_o,
    output logic                 busy_o
);

    logic sel;
    logic sel_q;
    logic lock_q;
    logic last_q;
    logic protocol_err_q;
    logic grant;
    logic fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic resp_pop;

    // Host selection: hold while locked, otherwise round-robin on contention.
    always_comb begin
        sel = last_q;
        if (lock_q) begin
            sel = sel_q;
        end else if (host_req_i == 2'b01) begin
            sel = 1'b0;
        end else if (host_req_i == 2'b10) begin
            sel = 1'b1;
        end else if (host_req_i == 2'b11) begin
            sel = ~last_q;
        end
    end

    // Full blocks new requests even if a pop lands in the same cycle.
    assign data_req_o   = host_req_i[sel] & ~fifo_full;
    assign grant        = data_req_o & data_gnt_i;
    assign data_we_o    = sel ? host_we_i[HOST_ACC] : host_we_i[HOST_LSU];
    assign data_be_o    = sel ? host_be_i[7:4] : host_be_i[3:0];
    assign data_addr_o  = sel ? host_addr_i[63:32] : host_addr_i[31:0];
    assign data_wdata_o = sel ? host_wdata_i[63:32] : host_wdata_i[31:0];
    assign host_gnt_o   = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Response routing: head of the ID FIFO owns the incoming rvalid.
    assign resp_pop      = data_rvalid_i & ~fifo_empty;
    assign host_rvalid_o = resp_pop ? (fifo_head ? 2'b10 : 2'b01) : 2'b00;
    assign host_err_o    = (resp_pop & data_err_i) ? (fifo_head ? 2'b10 : 2'b01) : 2'b00;
    assign host_rdata_o  = data_rdata_i;

    assign protocol_err_o = protocol_err_q;
    assign busy_o         = (outstanding_o != '0) | (|host_req_i);

    // Lock, round-robin history and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q         <= 1'b0;
            sel_q          <= 1'b0;
            last_q         <= 1'b1;
            protocol_err_q <= 1'b0;
        end else begin
            if (data_req_o & ~data_gnt_i) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end else if (grant | ~host_req_i[sel_q]) begin
                lock_q <= 1'b0;
            end
            if (grant) begin
                last_q <= sel;
            end
            if (data_rvalid_i & fifo_empty) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    ibex_data_bus_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (sel),
        .pop       (resp_pop),
        .head      (fifo_head),
        .count     (outstanding_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Directed bench for the data-bus arbiter with a queue-based reference model.
module tb_ibex_data_bus_arbiter;

    localparam int MAX_OUT = 2;
    localparam int CW      = $clog2(MAX_OUT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    host_req_i;
    logic [1:0]    host_we_i;
    logic [7:0]    host_be_i;
    logic [63:0]   host_addr_i;
    logic [63:0]   host_wdata_i;
    logic [1:0]    host_gnt_o;
    logic [1:0]    host_rvalid_o;
    logic [1:0]    host_err_o;
    logic [31:0]   host_rdata_o;
    logic          data_req_o;
    logic          data_gnt_i;
    logic          data_we_o;
    logic [3:0]    data_be_o;
    logic [31:0]   data_addr_o;
    logic [31:0]   data_wdata_o;
    logic          data_rvalid_i;
    logic          data_err_i;
    logic [31:0]   data_rdata_i;
    logic [CW-1:0] outstanding_o;
    logic          protocol_err_o;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibex_data_bus_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .host_req_i     (host_req_i),
        .host_we_i      (host_we_i),
        .host_be_i      (host_be_i),
        .host_addr_i    (host_addr_i),
        .host_wdata_i   (host_wdata_i),
        .host_gnt_o     (host_gnt_o),
        .host_rvalid_o  (host_rvalid_o),
        .host_err_o     (host_err_o),
        .host_rdata_o   (host_rdata_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_err_i     (data_err_i),
        .data_rdata_i   (data_rdata_i),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o),
        .busy_o         (busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner queue, waiting host, last winner, sticky error.
    int  q[$];
    int  pend  = -1;
    int  lastw = 1;
    bit  perr  = 1'b0;
    int  m_ch  = -1;
    bit  m_req = 1'b0;

    always @(negedge clk) begin
        logic [1:0] eg;
        logic [1:0] erv;
        logic [1:0] eerr;
        bit         ch_req;
        if (!rst) begin
            m_ch = -1;
            if (pend >= 0)                m_ch = pend;
            else if (host_req_i == 2'b01) m_ch = 0;
            else if (host_req_i == 2'b10) m_ch = 1;
            else if (host_req_i == 2'b11) m_ch = 1 - lastw;
            ch_req = (m_ch == 0) ? host_req_i[0] : (m_ch == 1) ? host_req_i[1] : 1'b0;
            m_req  = ch_req && (q.size() < MAX_OUT);
            eg     = (m_req && data_gnt_i) ? 2'(1 << m_ch) : 2'b00;
            erv    = 2'b00;
            eerr   = 2'b00;
            if (data_rvalid_i && q.size() > 0) begin
                erv  = 2'(1 << q[0]);
                eerr = data_err_i ? erv : 2'b00;
            end
            check("m_req", 64'(data_req_o), 64'(m_req));
            check("m_gnt", 64'(host_gnt_o), 64'(eg));
            check("m_rvalid", 64'(host_rvalid_o), 64'(erv));
            check("m_err", 64'(host_err_o), 64'(eerr));
            check("m_outst", 64'(outstanding_o), 64'(q.size()));
            check("m_perr", 64'(protocol_err_o), 64'(perr));
            check("m_busy", 64'(busy_o), 64'((q.size() != 0) || (host_req_i != 2'b00)));
            if (erv != 2'b00) check("m_rdata", 64'(host_rdata_o), 64'(data_rdata_i));
            if (m_req) begin
                check("m_addr", 64'(data_addr_o), 64'(host_addr_i[32*m_ch +: 32]));
                check("m_wdata", 64'(data_wdata_o), 64'(host_wdata_i[32*m_ch +: 32]));
                check("m_be", 64'(data_be_o), 64'(host_be_i[4*m_ch +: 4]));
                check("m_we", 64'(data_we_o), 64'(host_we_i[m_ch]));
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            pend  = -1;
            lastw = 1;
            perr  = 1'b0;
        end else begin
            if (data_rvalid_i) begin
                if (q.size() > 0) void'(q.pop_front());
                else perr = 1'b1;
            end
            if (m_req && data_gnt_i) begin
                q.push_back(m_ch);
                lastw = m_ch;
            end
            pend = (m_req && !data_gnt_i) ? m_ch : -1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic er, input logic [31:0] rd);
        host_req_i    = req;
        data_gnt_i    = gnt;
        data_rvalid_i = rv;
        data_err_i    = er;
        data_rdata_i  = rd;
    endtask

    initial begin
        rst          = 1'b1;
        host_we_i    = 2'b01;
        host_be_i    = 8'h3F;
        host_addr_i  = {32'h1000_0040, 32'h0000_0100};
        host_wdata_i = {32'hCAFE_1111, 32'hDEAD_0000};
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_outst", 64'(outstanding_o), 64'd0);
        check("rst_perr", 64'(protocol_err_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        tick();

        // Contention: host 0 first, then host 1; responses in order
        drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("s1_gnt_c1", 64'(host_gnt_o), 64'h1);
        check("s1_addr_c1", 64'(data_addr_o), 64'h0000_0100);
        tick();
        drive(2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("s1_gnt_c2", 64'(host_gnt_o), 64'h2);
        tick();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5);
        @(negedge clk);
        check("s1_rv_c3", 64'(host_rvalid_o), 64'h1);
        check("s1_rd_c3", 64'(host_rdata_o), 64'hA5A5_A5A5);
        tick();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h5A5A_5A5A);
        @(negedge clk);
        check("s1_rv_c4", 64'(host_rvalid_o), 64'h2);
        check("s1_rd_c4", 64'(host_rdata_o), 64'h5A5A_5A5A);
        tick();

        // Stalled host 1 keeps the bus while host 0 joins
        drive(2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("s2_addr_0", 64'(data_addr_o), 64'h1000_0040);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("s2_addr_hold", 64'(data_addr_o), 64'h1000_0040);
            tick();
        end
        drive(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("s2_gnt_h1", 64'(host_gnt_o), 64'h2);
        tick();
        drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("s2_gnt_h0", 64'(host_gnt_o), 64'h1);
        tick();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h1111_0001);
        @(negedge clk);
        check("s2_rv_h1", 64'(host_rvalid_o), 64'h2);
        tick();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h1111_0002);
        @(negedge clk);
        check("s2_rv_h0", 64'(host_rvalid_o), 64'h1);
        tick();

        // Dropped request releases the lock
        drive(2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("drop_gnt", 64'(host_gnt_o), 64'h0);
        tick();
        @(negedge clk);
        check("drop_gnt_next", 64'(host_gnt_o), 64'h1);
        tick();
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h2222_0000);
        tick();

        // Full FIFO blocks the third back-to-back request
        drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        @(negedge clk);
        check("s3_outst_full", 64'(outstanding_o), 64'd2);
        check("s3_req_blocked", 64'(data_req_o), 64'd0);
        check("s3_gnt_blocked", 64'(host_gnt_o), 64'd0);
        tick();
        drive(2'b01, 1'b1, 1'b1, 1'b0, 32'h3333_0001);
        @(negedge clk);
        check("s3_req_pop_cycle", 64'(data_req_o), 64'd0);
        check("s3_rv_pop", 64'(host_rvalid_o), 64'h1);
        tick();
        drive(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("s3_outst_after_pop", 64'(outstanding_o), 64'd1);
        check("s3_gnt_third", 64'(host_gnt_o), 64'h1);
        tick();

        // Grant and response together with one entry outstanding
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'h4444_0001);
        tick();
        drive(2'b10, 1'b1, 1'b1, 1'b0, 32'h4444_0002);
        @(negedge clk);
        check("s4_outst_before", 64'(outstanding_o), 64'd1);
        check("s4_rv_older", 64'(host_rvalid_o), 64'h1);
        check("s4_gnt_h1", 64'(host_gnt_o), 64'h2);
        tick();

        // Error response for host 1, one cycle only
        drive(2'b00, 1'b0, 1'b1, 1'b1, 32'hBAD0_0001);
        @(negedge clk);
        check("s4_outst_after", 64'(outstanding_o), 64'd1);
        check("s5_err", 64'(host_err_o), 64'h2);
        check("s5_rv", 64'(host_rvalid_o), 64'h2);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("s5_err_gone", 64'(host_err_o), 64'h0);
        check("s5_rv_gone", 64'(host_rvalid_o), 64'h0);
        tick();

        // Stray response with nothing outstanding
        drive(2'b00, 1'b0, 1'b1, 1'b0, 32'hFFFF_0000);
        @(negedge clk);
        check("s6_rv_dropped", 64'(host_rvalid_o), 64'h0);
        check("s6_perr_same", 64'(protocol_err_o), 64'd0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s6_perr_sticky", 64'(protocol_err_o), 64'd1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("s6_perr_cleared", 64'(protocol_err_o), 64'd0);
        check("s6_outst_cleared", 64'(outstanding_o), 64'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
